// File: rtl/axis_if.sv
// AXI-Stream point-to-point bundle (tdata/tvalid/tready).
//   m_axis : producer side  (drives tdata, tvalid; observes tready)
//   s_axis : consumer side  (observes tdata, tvalid; drives tready)
interface axis_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport m_axis (output tdata, output tvalid, input tready);
  modport s_axis (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx.sv
// UART receiver that packs DATA_BYTE consecutive frames into one AXI-Stream word.
// Frame: start, DATA_BITS data (LSB first), one parity bit, STOP_BITS stop bits.
// The first frame of a word lands in its most-significant byte.
// Ports:
//   aclk        clock
//   aresetn     synchronous active-low reset
//   uart_rx     serial line, idle high, asynchronous to aclk
//   rx_done     one-cycle pulse when a good word is loaded into the output register
//   parity_err  one-cycle pulse on a parity mismatch
//   frame_err   one-cycle pulse on a low stop bit or a false start
//   overrun     one-cycle pulse when a good word completes while the held word is unaccepted
//   m_axis      AXI-Stream master (tdata/tvalid/tready)
module axis_uart_rx #(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int CLOCK          = 100_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_BITS    = 0
) (
  input  logic   aclk,
  input  logic   aresetn,
  input  logic   uart_rx,
  output logic   rx_done,
  output logic   parity_err,
  output logic   frame_err,
  output logic   overrun,
  axis_if.m_axis m_axis
);

  localparam int COUNT_SPEED = CLOCK / BAUD_RATE;
  localparam int DATA_BYTE   = AXI_DATA_WIDTH / DATA_BITS;
  localparam int MAX_BITS    = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BAUD_W      = $clog2(COUNT_SPEED);
  localparam int BIT_W       = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int BYTE_W      = (DATA_BYTE > 1) ? $clog2(DATA_BYTE) : 1;
  localparam int IDX_W       = (AXI_DATA_WIDTH > 1) ? $clog2(AXI_DATA_WIDTH) : 1;

  // The start bit is checked half a bit after its falling edge; from then on
  // the counter restarts and every later bit is taken one full bit period
  // later, which keeps each sample near the middle of its bit.
  localparam logic [BAUD_W-1:0] HALF_BIT  = BAUD_W'(COUNT_SPEED / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_BIT  = BAUD_W'(COUNT_SPEED - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(DATA_BYTE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_COMMIT
  } state_t;

  // Expected parity bit for a received byte: even rule when PARITY_BITS is nonzero, odd otherwise.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    logic p;
    if (PARITY_BITS != 0) begin
      p = ^d;
    end else begin
      p = ~(^d);
    end
    return p;
  endfunction

  // Synchroniser chain; rx_sync_r is the clean line, rx_prev_r delays it once for edge detection.
  logic rx_meta_r, rx_sync_r, rx_prev_r;

  state_t                    state_r, state_nxt_s;
  logic [BAUD_W-1:0]         count_baud_r, count_baud_nxt_s;
  logic [BIT_W-1:0]          count_bit_r, count_bit_nxt_s;
  logic [BYTE_W-1:0]         count_byte_r, count_byte_nxt_s;
  logic [AXI_DATA_WIDTH-1:0] shift_r, shift_nxt_s;
  logic [AXI_DATA_WIDTH-1:0] tdata_r, tdata_nxt_s;
  logic                      tvalid_r, tvalid_nxt_s;
  logic                      word_bad_r, word_bad_nxt_s;
  logic                      rx_done_r, rx_done_nxt_s;
  logic                      parity_err_r, parity_err_nxt_s;
  logic                      frame_err_r, frame_err_nxt_s;
  logic                      overrun_r, overrun_nxt_s;

  logic                      fall_s;
  logic                      at_full_s;
  logic [IDX_W-1:0]          byte_base_s;
  logic [IDX_W-1:0]          bit_idx_s;
  logic [DATA_BITS-1:0]      byte_s;

  assign fall_s    = rx_prev_r & ~rx_sync_r;
  assign at_full_s = (count_baud_r == FULL_BIT);

  // Byte b of the word occupies bits starting at (DATA_BYTE-1-b)*DATA_BITS.
  assign byte_base_s = IDX_W'((DATA_BYTE - 1 - int'(count_byte_r)) * DATA_BITS);
  assign bit_idx_s   = IDX_W'((DATA_BYTE - 1 - int'(count_byte_r)) * DATA_BITS + int'(count_bit_r));
  assign byte_s      = DATA_BITS'(shift_r >> byte_base_s);

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Next-state, counter, datapath and pulse decode for the frame FSM.
  always_comb begin
    state_nxt_s      = state_r;
    count_baud_nxt_s = count_baud_r;
    count_bit_nxt_s  = count_bit_r;
    count_byte_nxt_s = count_byte_r;
    shift_nxt_s      = shift_r;
    word_bad_nxt_s   = word_bad_r;
    tdata_nxt_s      = tdata_r;
    // A completed handshake drops tvalid unless COMMIT reloads it below.
    tvalid_nxt_s     = tvalid_r & ~m_axis.tready;
    rx_done_nxt_s    = 1'b0;
    parity_err_nxt_s = 1'b0;
    frame_err_nxt_s  = 1'b0;
    overrun_nxt_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        count_baud_nxt_s = {BAUD_W{1'b0}};
        if (fall_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (count_baud_r == HALF_BIT) begin
          count_baud_nxt_s = {BAUD_W{1'b0}};
          if (!rx_sync_r) begin
            state_nxt_s = ST_DATA;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            frame_err_nxt_s  = 1'b1;
            count_byte_nxt_s = {BYTE_W{1'b0}};
            state_nxt_s      = ST_IDLE;
          end
        end else begin
          count_baud_nxt_s = count_baud_r + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (at_full_s) begin
          count_baud_nxt_s       = {BAUD_W{1'b0}};
          shift_nxt_s[bit_idx_s] = rx_sync_r;
          if (count_bit_r == LAST_DATA) begin
            count_bit_nxt_s = {BIT_W{1'b0}};
            state_nxt_s     = ST_PARITY;
          end else begin
            count_bit_nxt_s = count_bit_r + BIT_W'(1);
          end
        end else begin
          count_baud_nxt_s = count_baud_r + BAUD_W'(1);
        end
      end

      ST_PARITY: begin
        if (at_full_s) begin
          count_baud_nxt_s = {BAUD_W{1'b0}};
          state_nxt_s      = ST_STOP;
          if (rx_sync_r != parity_of(byte_s)) begin
            parity_err_nxt_s = 1'b1;
            word_bad_nxt_s   = 1'b1;
          end else begin
            word_bad_nxt_s   = word_bad_r;
          end
        end else begin
          count_baud_nxt_s = count_baud_r + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (at_full_s) begin
          count_baud_nxt_s = {BAUD_W{1'b0}};
          if (!rx_sync_r) begin
            frame_err_nxt_s = 1'b1;
            word_bad_nxt_s  = 1'b1;
          end else begin
            word_bad_nxt_s  = word_bad_r;
          end
          if (count_bit_r == LAST_STOP) begin
            count_bit_nxt_s = {BIT_W{1'b0}};
            if (count_byte_r == LAST_BYTE) begin
              state_nxt_s = ST_COMMIT;
            end else begin
              // More frames belong to this word; wait for the next start bit.
              count_byte_nxt_s = count_byte_r + BYTE_W'(1);
              state_nxt_s      = ST_IDLE;
            end
          end else begin
            count_bit_nxt_s = count_bit_r + BIT_W'(1);
          end
        end else begin
          count_baud_nxt_s = count_baud_r + BAUD_W'(1);
        end
      end

      ST_COMMIT: begin
        count_byte_nxt_s = {BYTE_W{1'b0}};
        word_bad_nxt_s   = 1'b0;
        state_nxt_s      = ST_IDLE;
        if (!word_bad_r) begin
          // The output register is free if empty or being accepted this very cycle.
          if (!tvalid_r || m_axis.tready) begin
            tdata_nxt_s   = shift_r;
            tvalid_nxt_s  = 1'b1;
            rx_done_nxt_s = 1'b1;
          end else begin
            overrun_nxt_s = 1'b1;
          end
        end else begin
          overrun_nxt_s = 1'b0;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, word assembly and registered outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= ST_IDLE;
      count_baud_r <= {BAUD_W{1'b0}};
      count_bit_r  <= {BIT_W{1'b0}};
      count_byte_r <= {BYTE_W{1'b0}};
      shift_r      <= {AXI_DATA_WIDTH{1'b0}};
      tdata_r      <= {AXI_DATA_WIDTH{1'b0}};
      tvalid_r     <= 1'b0;
      word_bad_r   <= 1'b0;
      rx_done_r    <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      count_baud_r <= count_baud_nxt_s;
      count_bit_r  <= count_bit_nxt_s;
      count_byte_r <= count_byte_nxt_s;
      shift_r      <= shift_nxt_s;
      tdata_r      <= tdata_nxt_s;
      tvalid_r     <= tvalid_nxt_s;
      word_bad_r   <= word_bad_nxt_s;
      rx_done_r    <= rx_done_nxt_s;
      parity_err_r <= parity_err_nxt_s;
      frame_err_r  <= frame_err_nxt_s;
      overrun_r    <= overrun_nxt_s;
    end
  end

  assign m_axis.tdata  = tdata_r;
  assign m_axis.tvalid = tvalid_r;
  assign rx_done       = rx_done_r;
  assign parity_err    = parity_err_r;
  assign frame_err     = frame_err_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Bench for axis_uart_rx: an 8-bit-word and a 16-bit-word receiver share the
// clock and reset, each with its own serial line. A monitor counts output
// pulses and logs accepted words; tests compare those against expectations.
module tb_axis_uart_rx;

  localparam int CS = 16;  // clocks per bit (CLOCK=16, BAUD_RATE=1)

  logic       clk = 1'b0;
  logic       aresetn;
  logic [1:0] line;
  logic       done8, perr8, ferr8, ovr8;
  logic       done16, perr16, ferr16, ovr16;

  axis_if #(.WIDTH(8))  if8 ();
  axis_if #(.WIDTH(16)) if16 ();

  always #5 clk = ~clk;

  axis_uart_rx #(
    .AXI_DATA_WIDTH(8), .CLOCK(16), .BAUD_RATE(1),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0)
  ) dut8 (
    .aclk(clk), .aresetn(aresetn), .uart_rx(line[0]),
    .rx_done(done8), .parity_err(perr8), .frame_err(ferr8), .overrun(ovr8),
    .m_axis(if8)
  );

  axis_uart_rx #(
    .AXI_DATA_WIDTH(16), .CLOCK(16), .BAUD_RATE(1),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0)
  ) dut16 (
    .aclk(clk), .aresetn(aresetn), .uart_rx(line[1]),
    .rx_done(done16), .parity_err(perr16), .frame_err(ferr16), .overrun(ovr16),
    .m_axis(if16)
  );

  // ---------------- monitor ----------------
  int          n_done [2];
  int          n_perr [2];
  int          n_ferr [2];
  int          n_ovr  [2];
  int          n_vcyc [2];
  logic [15:0] acc0 [$];
  logic [15:0] acc1 [$];

  initial begin
    for (int s = 0; s < 2; s++) begin
      n_done[s] = 0; n_perr[s] = 0; n_ferr[s] = 0; n_ovr[s] = 0; n_vcyc[s] = 0;
    end
  end

  always @(negedge clk) begin
    if (done8  === 1'b1) n_done[0] <= n_done[0] + 1;
    if (perr8  === 1'b1) n_perr[0] <= n_perr[0] + 1;
    if (ferr8  === 1'b1) n_ferr[0] <= n_ferr[0] + 1;
    if (ovr8   === 1'b1) n_ovr[0]  <= n_ovr[0] + 1;
    if (done16 === 1'b1) n_done[1] <= n_done[1] + 1;
    if (perr16 === 1'b1) n_perr[1] <= n_perr[1] + 1;
    if (ferr16 === 1'b1) n_ferr[1] <= n_ferr[1] + 1;
    if (ovr16  === 1'b1) n_ovr[1]  <= n_ovr[1] + 1;
    if (if8.tvalid === 1'b1)  n_vcyc[0] <= n_vcyc[0] + 1;
    if (if16.tvalid === 1'b1) n_vcyc[1] <= n_vcyc[1] + 1;
    if (if8.tvalid === 1'b1 && if8.tready === 1'b1)   acc0.push_back({8'h00, if8.tdata});
    if (if16.tvalid === 1'b1 && if16.tready === 1'b1) acc1.push_back(if16.tdata);
  end

  // ---------------- checking helpers ----------------
  int pass_cnt = 0;
  int check_cnt = 0;
  int b_done [2];
  int b_perr [2];
  int b_ferr [2];
  int b_ovr  [2];
  int b_vcyc [2];
  int b_acc  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int sel, input logic b);
    line[sel] = b;
    tick(CS);
  endtask

  // Odd-parity bit: total number of ones including the parity bit is odd.
  function automatic logic odd_par(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) if (d[k]) ones++;
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // One frame plus one idle bit; pbad flips the parity bit, sbad drives the stop bit low.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic pbad, input logic sbad);
    drive_bit(sel, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(sel, d[k]);
    drive_bit(sel, odd_par(d) ^ pbad);
    drive_bit(sel, ~sbad);
    drive_bit(sel, 1'b1);
  endtask

  function automatic int acc_size(input int sel);
    return (sel == 0) ? acc0.size() : acc1.size();
  endfunction

  function automatic logic [15:0] acc_last(input int sel);
    if (sel == 0) return (acc0.size() > 0) ? acc0[acc0.size()-1] : 16'hxxxx;
    else          return (acc1.size() > 0) ? acc1[acc1.size()-1] : 16'hxxxx;
  endfunction

  task automatic snap();
    for (int s = 0; s < 2; s++) begin
      b_done[s] = n_done[s]; b_perr[s] = n_perr[s]; b_ferr[s] = n_ferr[s];
      b_ovr[s]  = n_ovr[s];  b_vcyc[s] = n_vcyc[s]; b_acc[s]  = acc_size(s);
    end
  endtask

  task automatic check_deltas(input int sel, input string tag, input int ed, input int ep,
                              input int ef, input int eo, input logic [15:0] ew);
    check({tag, "_done"},    32'(n_done[sel] - b_done[sel]), 32'(ed));
    check({tag, "_perr"},    32'(n_perr[sel] - b_perr[sel]), 32'(ep));
    check({tag, "_ferr"},    32'(n_ferr[sel] - b_ferr[sel]), 32'(ef));
    check({tag, "_ovr"},     32'(n_ovr[sel] - b_ovr[sel]),   32'(eo));
    check({tag, "_accepts"}, 32'(acc_size(sel) - b_acc[sel]), 32'(ed));
    if (ed == 1) check({tag, "_word"}, 32'(acc_last(sel)), 32'(ew));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          sel;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [1:0]  pbad;
    logic [1:0]  sbad;
    int          ed;
    int          ep;
    int          ef;
    int          ev;
    logic [15:0] w;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sel, nb, ep, ef, ed;
    logic [7:0]  rb [2];
    logic [1:0]  pb, sb;
    logic [15:0] ew;

    //               sel n  b0     b1     pbad   sbad   done perr ferr vcyc word
    vecs[0] = '{0, 1, 8'hA5, 8'h00, 2'b00, 2'b00, 1, 0, 0, 1, 16'h00A5};
    vecs[1] = '{1, 2, 8'h12, 8'h34, 2'b00, 2'b00, 1, 0, 0, 1, 16'h1234};
    vecs[2] = '{0, 1, 8'h5A, 8'h00, 2'b01, 2'b00, 0, 1, 0, 0, 16'h0000};
    vecs[3] = '{0, 1, 8'h5A, 8'h00, 2'b00, 2'b00, 1, 0, 0, 1, 16'h005A};
    vecs[4] = '{0, 1, 8'hC3, 8'h00, 2'b00, 2'b01, 0, 0, 1, 0, 16'h0000};
    vecs[5] = '{1, 2, 8'h12, 8'h34, 2'b01, 2'b00, 0, 1, 0, 0, 16'h0000};
    vecs[6] = '{1, 2, 8'h56, 8'h78, 2'b00, 2'b10, 0, 0, 1, 0, 16'h0000};
    vecs[7] = '{1, 2, 8'h9A, 8'hBC, 2'b11, 2'b00, 0, 2, 0, 0, 16'h0000};

    // Reset state
    aresetn = 1'b0;
    line = 2'b11;
    if8.tready = 1'b1;
    if16.tready = 1'b1;
    tick(5);
    check("rst_tvalid8",  32'(if8.tvalid),  32'd0);
    check("rst_tdata8",   32'(if8.tdata),   32'd0);
    check("rst_tvalid16", 32'(if16.tvalid), 32'd0);
    check("rst_tdata16",  32'(if16.tdata),  32'd0);
    check("rst_pulses8",  32'({done8, perr8, ferr8, ovr8}),     32'd0);
    check("rst_pulses16", 32'({done16, perr16, ferr16, ovr16}), 32'd0);
    aresetn = 1'b1;
    tick(5);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      snap();
      send_frame(vecs[i].sel, vecs[i].b0, vecs[i].pbad[0], vecs[i].sbad[0]);
      if (vecs[i].nbytes == 2) begin
        check($sformatf("vec%0d_first_frame_done", i),
              32'(n_done[vecs[i].sel] - b_done[vecs[i].sel]), 32'd0);
        send_frame(vecs[i].sel, vecs[i].b1, vecs[i].pbad[1], vecs[i].sbad[1]);
      end
      tick(4);
      check_deltas(vecs[i].sel, $sformatf("vec%0d", i),
                   vecs[i].ed, vecs[i].ep, vecs[i].ef, 0, vecs[i].w);
      check($sformatf("vec%0d_valid_cycles", i),
            32'(n_vcyc[vecs[i].sel] - b_vcyc[vecs[i].sel]), 32'(vecs[i].ev));
    end

    // False start: 4-clock low glitch, then a good frame
    snap();
    line[0] = 1'b0;
    tick(4);
    line[0] = 1'b1;
    tick(2 * CS);
    check_deltas(0, "glitch", 0, 0, 1, 0, 16'h0000);
    check("glitch_tvalid", 32'(if8.tvalid), 32'd0);
    snap();
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    tick(4);
    check_deltas(0, "after_glitch", 1, 0, 0, 0, 16'h003C);

    // Overrun: hold tready low across two words
    if8.tready = 1'b0;
    snap();
    send_frame(0, 8'h11, 1'b0, 1'b0);
    tick(4);
    check("ovr_first_done",   32'(n_done[0] - b_done[0]), 32'd1);
    check("ovr_first_tvalid", 32'(if8.tvalid), 32'd1);
    check("ovr_first_tdata",  32'(if8.tdata),  32'h11);
    snap();
    send_frame(0, 8'h22, 1'b0, 1'b0);
    tick(4);
    check_deltas(0, "ovr_second", 0, 0, 0, 1, 16'h0000);
    check("ovr_hold_tvalid", 32'(if8.tvalid), 32'd1);
    check("ovr_hold_tdata",  32'(if8.tdata),  32'h11);
    snap();
    if8.tready = 1'b1;
    tick(3);
    check("ovr_accept_count", 32'(acc_size(0) - b_acc[0]), 32'd1);
    check("ovr_accept_word",  32'(acc_last(0)), 32'h0011);
    check("ovr_tvalid_drop",  32'(if8.tvalid), 32'd0);
    tick(2 * CS);
    check("ovr_no_second",    32'(acc_size(0) - b_acc[0]), 32'd1);

    // Reset mid-frame: partial word pending on the 16-bit receiver,
    // 8-bit receiver halfway through its data bits
    send_frame(1, 8'hAB, 1'b0, 1'b0);
    drive_bit(0, 1'b0);
    for (int k = 0; k < 4; k++) drive_bit(0, 1'b0);
    snap();
    aresetn = 1'b0;
    line[0] = 1'b1;
    tick(3);
    check("midrst_tvalid8",  32'(if8.tvalid),  32'd0);
    check("midrst_tdata8",   32'(if8.tdata),   32'd0);
    check("midrst_tvalid16", 32'(if16.tvalid), 32'd0);
    aresetn = 1'b1;
    tick(3 * CS);
    check_deltas(0, "midrst8",  0, 0, 0, 0, 16'h0000);
    check_deltas(1, "midrst16", 0, 0, 0, 0, 16'h0000);
    snap();
    send_frame(0, 8'h77, 1'b0, 1'b0);
    tick(4);
    check_deltas(0, "post_rst8", 1, 0, 0, 0, 16'h0077);
    snap();
    send_frame(1, 8'h77, 1'b0, 1'b0);
    send_frame(1, 8'h66, 1'b0, 1'b0);
    tick(4);
    check_deltas(1, "post_rst16", 1, 0, 0, 0, 16'h7766);

    // Randomized words against a frame-level reference model
    for (int i = 0; i < 20; i++) begin
      sel   = int'($urandom_range(1, 0));
      nb    = (sel == 1) ? 2 : 1;
      rb[0] = 8'($urandom);
      rb[1] = 8'($urandom);
      pb    = 2'b00;
      sb    = 2'b00;
      for (int j = 0; j < 2; j++) begin
        pb[j] = ($urandom_range(5, 0) == 0);
        sb[j] = ($urandom_range(7, 0) == 0);
      end
      // Model: a word is delivered only if every frame of it is clean;
      // each bad parity and each low stop bit gives one pulse.
      ep = 0;
      ef = 0;
      for (int j = 0; j < nb; j++) begin
        if (pb[j]) ep++;
        if (sb[j]) ef++;
      end
      ed = (ep == 0 && ef == 0) ? 1 : 0;
      ew = (nb == 2) ? {rb[0], rb[1]} : {8'h00, rb[0]};
      snap();
      for (int j = 0; j < nb; j++) send_frame(sel, rb[j], pb[j], sb[j]);
      tick(int'($urandom_range(20, 4)));
      check_deltas(sel, $sformatf("rand%0d", i), ed, ep, ef, 0, ew);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
